// File: rtl/mult_share_arbiter_pkg.sv
// Shared defaults for the multiplier-sharing arbiter.
// MULT_LAT is the external multiplier's input-register plus output-register delay.
package mult_share_arbiter_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_RSP_DEPTH  = 4;
    localparam int MULT_LAT       = 2;
endpackage

// File: rtl/mult_share_arbiter_rr_grant.sv
// rr_grant: one-hot round-robin grant, search starts at ptr_i. Purely combinational.
// No backpressure of its own; the caller masks req_i when it cannot accept.
module rr_grant #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         gnt_o
);
    localparam int PW = $clog2(N);
    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            // Wrap explicitly so non-power-of-two N stays in range.
            sum = {1'b0, ptr_i} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin share of one external registered multiplier; issue->rsp_valid 3 cycles.
// req_ready held low while in-flight + buffered results fill the response FIFO; MULT_ARB_STATS_EN adds op_count.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [2*DATA_WIDTH-1:0]         rsp_result,
    output logic                            mult_enable,
    output logic [DATA_WIDTH-1:0]           mult_a,
    output logic [DATA_WIDTH-1:0]           mult_b,
    input  logic [2*DATA_WIDTH-1:0]         mult_result,
    output logic                            busy,
    output logic [15:0]                     op_count
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [ID_W-1:0]         id;
        logic [2*DATA_WIDTH-1:0] res;
    } rsp_t;

    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [MULT_LAT-1:0] pvld_q;
    logic [ID_W-1:0]     pid_q [MULT_LAT];
    rsp_t                fifo_q [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OCC_W-1:0]    occ;
    logic                can_issue, issue, push, pop;
    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_id;
    rsp_t                push_ent;

    // Occupancy counts results already committed to the pipeline, so the FIFO can never overflow.
    always_comb begin
        occ = {1'b0, cnt_q};
        for (int s = 0; s < MULT_LAT; s++) begin
            occ = occ + OCC_W'(pvld_q[s]);
        end
        can_issue = !rst && (occ < OCC_W'(RSP_DEPTH));
    end

    rr_grant #(.N(NUM_REQ)) u_rr_grant (
        .req_i (req_valid & {NUM_REQ{can_issue}}),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    always_comb begin
        issue  = |gnt;
        gnt_id = '0;
        mult_a = '0;
        mult_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id = ID_W'(i);
                mult_a = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                mult_b = req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    assign req_ready   = gnt;
    assign mult_enable = issue | (|pvld_q);
    assign push        = pvld_q[MULT_LAT-1];
    assign rsp_valid   = (cnt_q != '0);
    assign pop         = rsp_valid & rsp_ready;
    assign rsp_id      = fifo_q[rd_ptr_q].id;
    assign rsp_result  = fifo_q[rd_ptr_q].res;
    assign busy        = (|pvld_q) | rsp_valid;
    assign push_ent    = '{id: pid_q[MULT_LAT-1], res: mult_result};

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            pvld_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int s = 0; s < MULT_LAT; s++) begin
                pid_q[s] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            pvld_q   <= {pvld_q[MULT_LAT-2:0], issue};
            pid_q[0] <= gnt_id;
            for (int s = 1; s < MULT_LAT; s++) begin
                pid_q[s] <= pid_q[s-1];
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: validity is carried entirely by cnt_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_ent;
        end
    end

`ifdef MULT_ARB_STATS_EN
    logic [15:0] op_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_q <= '0;
        end else if (pop && (op_cnt_q != 16'hFFFF)) begin
            op_cnt_q <= op_cnt_q + 16'd1;
        end
    end

    assign op_count = op_cnt_q;
`else
    assign op_count = '0;
`endif
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: queue-based reference model checked every cycle plus directed literal checks.
module tb_mult_share_arbiter;
    localparam int DW = 32;
    localparam int N  = 4;
    localparam int D  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [2*DW-1:0] rsp_result;
    logic            mult_enable;
    logic [DW-1:0]   mult_a, mult_b;
    logic [2*DW-1:0] mult_result;
    logic            busy;
    logic [15:0]     op_count;

    always #5 clk = ~clk;

    mult_share_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .RSP_DEPTH(D)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .mult_enable(mult_enable), .mult_a(mult_a), .mult_b(mult_b),
        .mult_result(mult_result), .busy(busy), .op_count(op_count)
    );

    // External multiplier: input register then output register.
    logic [DW-1:0]   ma_q, mb_q;
    logic [2*DW-1:0] mr_q;
    always @(posedge clk) begin
        if (mult_enable) begin
            ma_q <= mult_a;
            mb_q <= mult_b;
            mr_q <= {{DW{1'b0}}, ma_q} * {{DW{1'b0}}, mb_q};
        end
    end
    assign mult_result = mr_q;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: outstanding operations in issue order with their issue cycle.
    typedef struct {
        int          id;
        logic [63:0] prod;
        int          ic;
    } ent_t;

    ent_t mq[$];
    int   mp    = 0;
    int   mpops = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : cmp
        int          g;
        int          c;
        logic [N-1:0] er;
        logic        ev, een;
        logic [63:0] ea, eb, eop;
        ent_t        e;
        if (rst) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_mult_enable", 64'(mult_enable), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_mult_a", 64'(mult_a), 64'd0);
            chk("rst_mult_b", 64'(mult_b), 64'd0);
            chk("rst_op_count", 64'(op_count), 64'd0);
            mq.delete();
            mp    = 0;
            mpops = 0;
        end else begin
            g = -1;
            if (mq.size() < D) begin
                for (int k = 0; k < N; k++) begin
                    c = (mp + k) % N;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            er = '0;
            ea = 64'd0;
            eb = 64'd0;
            if (g >= 0) begin
                er[g] = 1'b1;
                ea    = 64'(req_a[g*DW +: DW]);
                eb    = 64'(req_b[g*DW +: DW]);
            end
            een = (g >= 0);
            foreach (mq[j]) if (mq[j].ic >= cyc - 2) een = 1'b1;
            ev = (mq.size() > 0) && (mq[0].ic + 3 <= cyc);
`ifdef MULT_ARB_STATS_EN
            eop = 64'(mpops);
`else
            eop = 64'd0;
`endif
            chk("req_ready", 64'(req_ready), 64'(er));
            chk("mult_a", 64'(mult_a), ea);
            chk("mult_b", 64'(mult_b), eb);
            chk("mult_enable", 64'(mult_enable), 64'(een));
            chk("busy", 64'(busy), 64'(mq.size() > 0));
            chk("rsp_valid", 64'(rsp_valid), 64'(ev));
            chk("op_count", 64'(op_count), eop);
            if (ev) begin
                chk("rsp_id", 64'(rsp_id), 64'(mq[0].id));
                chk("rsp_result", rsp_result, mq[0].prod);
                if (rsp_ready) begin
                    void'(mq.pop_front());
                    if (mpops < 65535) mpops++;
                end
            end
            if (g >= 0) begin
                e.id   = g;
                e.prod = ea * eb;
                e.ic   = cyc;
                mq.push_back(e);
                mp = (g + 1) % N;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int          nis;
    int          gseq[$];
    int          rseq[$];
    logic [63:0] r0;
    int          exp_g[5] = '{0, 1, 2, 3, 0};

    initial begin
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        rst       = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ready_gated", 64'(req_ready), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        tick();
        rst       = 1'b0;
        req_valid = '0;

        // Single request 3*5 issued in cycle 1.
        tick();
        req_valid       = 4'b0001;
        req_a[0 +: DW]  = 32'd3;
        req_b[0 +: DW]  = 32'd5;
        rsp_ready       = 1'b1;
        @(negedge clk);
        chk("c1_ready", 64'(req_ready), 64'd1);
        chk("c1_enable", 64'(mult_enable), 64'd1);
        chk("c1_mult_a", 64'(mult_a), 64'd3);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("c2_enable", 64'(mult_enable), 64'd1);
        chk("c2_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("c3_enable", 64'(mult_enable), 64'd1);
        chk("c3_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("c4_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("c4_rsp_id", 64'(rsp_id), 64'd0);
        chk("c4_rsp_result", rsp_result, 64'd15);
        chk("c4_enable", 64'(mult_enable), 64'd0);
        tick();
        @(negedge clk);
        chk("c5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("c5_busy", 64'(busy), 64'd0);

        // Maximum operands on requester 2 (pointer now at 1).
        tick();
        req_valid       = 4'b0100;
        req_a[2*DW +: DW] = 32'hFFFF_FFFF;
        req_b[2*DW +: DW] = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("max_grant", 64'(req_ready), 64'h4);
        tick();
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        chk("max_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("max_rsp_id", 64'(rsp_id), 64'd2);
        chk("max_rsp_result", rsp_result, 64'hFFFF_FFFE_0000_0001);
        repeat (3) tick();

        // Backpressure: exactly D issues, then no further grants.
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = 32'(i + 11);
            req_b[i*DW +: DW] = 32'(i + 20);
        end
        rsp_ready = 1'b0;
        tick();
        req_valid = '1;
        nis = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (|req_ready) nis++;
            tick();
        end
        @(negedge clk);
        chk("bp_issue_count", 64'(nis), 64'(D));
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_busy", 64'(busy), 64'd1);
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_full", 64'(req_ready), 64'd0);
        tick();
        @(negedge clk);
        chk("bp_resume", 64'(|req_ready), 64'd1);
        tick();
        req_valid = '0;
        repeat (8) tick();

        // Reset with two operations in flight and one buffered.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (3) tick();
        req_valid = '0;
        @(negedge clk);
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("mid_enable", 64'(mult_enable), 64'd1);
        #1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("post_rst_busy", 64'(busy), 64'd0);
            tick();
        end

        // All requesters continuously valid for five cycles from pointer 0.
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = 32'(i + 7);
            req_b[i*DW +: DW] = 32'(i + 9);
        end
        req_valid = '1;
        r0 = '0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) if (req_ready[k]) gseq.push_back(k);
            if (rsp_valid) begin
                if (rseq.size() == 0) r0 = rsp_result;
                rseq.push_back(int'(rsp_id));
            end
            tick();
            if (i == 4) req_valid = '0;
        end
        chk("rr_grant_count", 64'(gseq.size()), 64'd5);
        chk("rr_rsp_count", 64'(rseq.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_grant_order", 64'((k < gseq.size()) ? gseq[k] : -1), 64'(exp_g[k]));
            chk("rr_rsp_order", 64'((k < rseq.size()) ? rseq[k] : -1), 64'(exp_g[k]));
        end
        chk("rr_first_result", r0, 64'd63);
        @(negedge clk);
`ifdef MULT_ARB_STATS_EN
        chk("op_count_five", 64'(op_count), 64'd5);
`else
        chk("op_count_tied", 64'(op_count), 64'd0);
`endif
        chk("final_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
